multiplicant_gen: RTL and testbench

Registered partial-product generator for the quantized neural-network datapath on the FPGA.
- For each of N_INPUTS lanes it ANDs every activation bit with every weight bit, producing the full bit-level partial-product matrix.
- It also produces the per-lane unsigned product (sum of shifted partial products).
- Sits between the input/weight fetch stage and the accumulator/popcount tree.

---
 rtl/multiplicant_gen_pkg.sv | 23 ++
 rtl/multiplicant_lane.sv | 44 ++++
 rtl/multiplicant_gen.sv | 62 ++++++
 tb/tb_multiplicant_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/multiplicant_gen_pkg.sv
// Width and packed-bus index helpers shared by the partial-product generator
// and its per-lane sub-module.
package multiplicant_gen_pkg;

    function automatic int pp_bits(input int input_bits, input int weight_bits);
        return input_bits * weight_bits;
    endfunction

    function automatic int prod_bits(input int input_bits, input int weight_bits);
        return input_bits + weight_bits;
    endfunction

    // Flat position of partial product (activation bit a, weight bit b) of a lane.
    function automatic int pp_index(input int lane, input int a, input int b,
                                    input int input_bits, input int weight_bits);
        return (lane * input_bits + a) * weight_bits + b;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/multiplicant_lane.sv
// Combinational partial-product matrix and unsigned product for one
// activation/weight pair.
module multiplicant_lane
    import multiplicant_gen_pkg::*;
#(
    parameter int INPUT_BITS  = 3,
    parameter int WEIGHT_BITS = 3
) (
    input  logic [INPUT_BITS-1:0]                              activation,
    input  logic [WEIGHT_BITS-1:0]                             weight,
    output logic [pp_bits(INPUT_BITS, WEIGHT_BITS)-1:0]        partials,
    output logic [prod_bits(INPUT_BITS, WEIGHT_BITS)-1:0]      product
);

    localparam int PROD_BITS = prod_bits(INPUT_BITS, WEIGHT_BITS);

    generate
        for (genvar gi = 0; gi < INPUT_BITS; gi++) begin : g_act
            for (genvar gj = 0; gj < WEIGHT_BITS; gj++) begin : g_wgt
                assign partials[pp_index(0, gi, gj, INPUT_BITS, WEIGHT_BITS)] =
                    activation[gi] & weight[gj];
            end
        end
    endgenerate

    // Shift-and-add of the bit matrix; the sum fits PROD_BITS by construction.
    logic [PROD_BITS-1:0] sum;
    logic [PROD_BITS-1:0] term;

    always_comb begin
        sum  = '0;
        term = '0;
        for (int a = 0; a < INPUT_BITS; a++) begin
            for (int b = 0; b < WEIGHT_BITS; b++) begin
                term = {{(PROD_BITS-1){1'b0}},
                        partials[pp_index(0, a, b, INPUT_BITS, WEIGHT_BITS)]};
                sum  = sum + (term << (a + b));
            end
        end
    end

    assign product = sum;

endmodule

// File: rtl/multiplicant_gen.sv
// Registered partial-product generator: N_INPUTS independent lanes feeding
// bit matrices and unsigned products to the accumulator tree, 1-cycle latency.
module multiplicant_gen
    import multiplicant_gen_pkg::*;
#(
    parameter int N_INPUTS    = 4,
    parameter int WEIGHT_BITS = 3,
    parameter int INPUT_BITS  = 3
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     in_valid,
    input  logic [N_INPUTS*INPUT_BITS-1:0]                           inputs,
    input  logic [N_INPUTS*WEIGHT_BITS-1:0]                          weights,
    output logic                                                     out_valid,
    output logic [N_INPUTS*INPUT_BITS*WEIGHT_BITS-1:0]               multiplicants,
    output logic [N_INPUTS*(INPUT_BITS+WEIGHT_BITS)-1:0]             products
);

    localparam int PP_BITS   = pp_bits(INPUT_BITS, WEIGHT_BITS);
    localparam int PROD_BITS = prod_bits(INPUT_BITS, WEIGHT_BITS);

    logic [N_INPUTS*PP_BITS-1:0]   multiplicants_next;
    logic [N_INPUTS*PP_BITS-1:0]   multiplicants_reg;
    logic [N_INPUTS*PROD_BITS-1:0] products_next;
    logic [N_INPUTS*PROD_BITS-1:0] products_reg;
    logic                          out_valid_reg;

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_lane
            multiplicant_lane #(
                .INPUT_BITS  (INPUT_BITS),
                .WEIGHT_BITS (WEIGHT_BITS)
            ) u_lane (
                .activation (inputs[lane_lsb(gi, INPUT_BITS) +: INPUT_BITS]),
                .weight     (weights[lane_lsb(gi, WEIGHT_BITS) +: WEIGHT_BITS]),
                .partials   (multiplicants_next[lane_lsb(gi, PP_BITS) +: PP_BITS]),
                .product    (products_next[lane_lsb(gi, PROD_BITS) +: PROD_BITS])
            );
        end
    endgenerate

    // Data registers hold when no new set arrives; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            multiplicants_reg <= '0;
            products_reg      <= '0;
            out_valid_reg     <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                multiplicants_reg <= multiplicants_next;
                products_reg      <= products_next;
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign multiplicants = multiplicants_reg;
    assign products      = products_reg;

endmodule

// File: tb/tb_multiplicant_gen.sv
// Directed and randomized checks of multiplicant_gen at default parameters
// and at N_INPUTS=2, INPUT_BITS=4, WEIGHT_BITS=2.
module tb_multiplicant_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Default-parameter instance
    logic        in_valid_a = 1'b0;
    logic [11:0] inputs_a   = '0;
    logic [11:0] weights_a  = '0;
    logic        out_valid_a;
    logic [35:0] mult_a;
    logic [23:0] prod_a;

    // Sweep instance: N=2, IB=4, WB=2
    logic        in_valid_b = 1'b0;
    logic [7:0]  inputs_b   = '0;
    logic [3:0]  weights_b  = '0;
    logic        out_valid_b;
    logic [15:0] mult_b;
    logic [11:0] prod_b;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    multiplicant_gen dut_a (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid_a),
        .inputs        (inputs_a),
        .weights       (weights_a),
        .out_valid     (out_valid_a),
        .multiplicants (mult_a),
        .products      (prod_a)
    );

    multiplicant_gen #(
        .N_INPUTS    (2),
        .WEIGHT_BITS (2),
        .INPUT_BITS  (4)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid_b),
        .inputs        (inputs_b),
        .weights       (weights_b),
        .out_valid     (out_valid_b),
        .multiplicants (mult_b),
        .products      (prod_b)
    );

    function automatic logic [35:0] mult_model_a(input logic [11:0] in, input logic [11:0] w);
        logic [35:0] r = '0;
        for (int i = 0; i < 4; i++)
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < 3; b++)
                    r[(i*3 + a)*3 + b] = in[i*3 + a] & w[i*3 + b];
        return r;
    endfunction

    function automatic logic [23:0] prod_model_a(input logic [11:0] in, input logic [11:0] w);
        logic [23:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[i*6 +: 6] = 6'(in[i*3 +: 3]) * 6'(w[i*3 +: 3]);
        return r;
    endfunction

    function automatic logic [15:0] mult_model_b(input logic [7:0] in, input logic [3:0] w);
        logic [15:0] r = '0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 2; b++)
                    r[(i*4 + a)*2 + b] = in[i*4 + a] & w[i*2 + b];
        return r;
    endfunction

    function automatic logic [11:0] prod_model_b(input logic [7:0] in, input logic [3:0] w);
        logic [11:0] r = '0;
        for (int i = 0; i < 2; i++)
            r[i*6 +: 6] = 6'(in[i*4 +: 4]) * 6'(w[i*2 +: 2]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        asserts++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic v, input logic [35:0] m, input logic [23:0] p);
        check({tag, ".valid"}, 64'(out_valid_a), 64'(v));
        check({tag, ".mult"},  64'(mult_a),      64'(m));
        check({tag, ".prod"},  64'(prod_a),      64'(p));
        $display("%s: valid=%0d mult=%h prod=%h", tag, out_valid_a, mult_a, prod_a);
    endtask

    logic [11:0] exp_in;
    logic [11:0] exp_w;
    logic [11:0] set_in;
    logic [11:0] set_w;
    logic [15:0] hold_mb;
    logic [11:0] hold_pb;
    logic        exp_vb;

    initial begin
        // Reset state, even with in_valid asserted
        in_valid_a = 1'b1;
        inputs_a   = 12'hFFF;
        weights_a  = 12'hFFF;
        step();
        step();
        check_a("reset", 1'b0, 36'h0, 24'h0);
        rst        = 1'b0;
        in_valid_a = 1'b0;
        step();
        check_a("idle_after_reset", 1'b0, 36'h0, 24'h0);

        // Lane-0 basic: 5 * 3
        in_valid_a = 1'b1;
        inputs_a   = 12'b000_000_000_101;
        weights_a  = 12'b000_000_000_011;
        step();
        check_a("lane0_basic", 1'b1, 36'h0_0000_00C3, {6'd0, 6'd0, 6'd0, 6'd15});

        // All ones
        inputs_a  = 12'hFFF;
        weights_a = 12'hFFF;
        step();
        check_a("all_ones", 1'b1, 36'hF_FFFF_FFFF, {6'd49, 6'd49, 6'd49, 6'd49});

        // Zero weights
        weights_a = 12'h000;
        step();
        check_a("zero_weights", 1'b1, 36'h0, 24'h0);

        // Streaming: lane i gets input i+1, weight 7-i; later sets rotate the operands
        set_in = {3'd4, 3'd3, 3'd2, 3'd1};
        set_w  = {3'd4, 3'd5, 3'd6, 3'd7};
        inputs_a  = set_in;
        weights_a = set_w;
        step();
        check_a("stream0", 1'b1, mult_model_a(set_in, set_w), {6'd16, 6'd15, 6'd12, 6'd7});
        for (int k = 1; k < 6; k++) begin
            exp_in    = {set_in[8:0], set_in[11:9]} ^ 12'(k * 12'h249);
            exp_w     = {set_w[2:0], set_w[11:3]} + 12'(k * 12'h111);
            inputs_a  = exp_in;
            weights_a = exp_w;
            step();
            check_a($sformatf("stream%0d", k), 1'b1,
                    mult_model_a(exp_in, exp_w), prod_model_a(exp_in, exp_w));
        end
        in_valid_a = 1'b0;
        inputs_a   = 12'hFFF;
        weights_a  = 12'hFFF;
        step();
        check_a("stream_hold", 1'b0, mult_model_a(exp_in, exp_w), prod_model_a(exp_in, exp_w));

        // Reset mid-stream discards the in-flight set
        in_valid_a = 1'b1;
        rst        = 1'b1;
        step();
        check_a("reset_midstream", 1'b0, 36'h0, 24'h0);
        rst       = 1'b0;
        inputs_a  = set_in;
        weights_a = set_w;
        step();
        check_a("after_reset", 1'b1, mult_model_a(set_in, set_w), {6'd16, 6'd15, 6'd12, 6'd7});
        in_valid_a = 1'b0;

        // Parameter sweep on the second instance with random operands and valids
        hold_mb = '0;
        hold_pb = '0;
        exp_vb  = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            in_valid_b = ($urandom_range(0, 3) != 0);
            inputs_b   = 8'($urandom);
            weights_b  = 4'($urandom);
            if (in_valid_b) begin
                hold_mb = mult_model_b(inputs_b, weights_b);
                hold_pb = prod_model_b(inputs_b, weights_b);
            end
            exp_vb = in_valid_b;
            step();
            asserts++;
            assert (out_valid_b === exp_vb && mult_b === hold_mb && prod_b === hold_pb) else begin
                fails++;
                $error("FAIL sweep%0d: observed v=%0d m=%h p=%h expected v=%0d m=%h p=%h",
                       n, out_valid_b, mult_b, prod_b, exp_vb, hold_mb, hold_pb);
            end
            if (n % 100 == 0)
                $display("sweep%0d: valid=%0d mult=%h prod=%h", n, out_valid_b, mult_b, prod_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
